// File: rtl/simple_datapath_pkg.sv
// rtl/simple_datapath_pkg.sv - function-select codes and status flag bit positions for simple_datapath
package simple_datapath_pkg;

    localparam logic [3:0] FS_TRA  = 4'b0000;
    localparam logic [3:0] FS_INC  = 4'b0001;
    localparam logic [3:0] FS_ADD  = 4'b0010;
    localparam logic [3:0] FS_ADDC = 4'b0011;
    localparam logic [3:0] FS_SUBB = 4'b0100;
    localparam logic [3:0] FS_SUB  = 4'b0101;
    localparam logic [3:0] FS_DEC  = 4'b0110;
    localparam logic [3:0] FS_AND  = 4'b1000;
    localparam logic [3:0] FS_OR   = 4'b1001;
    localparam logic [3:0] FS_XOR  = 4'b1010;
    localparam logic [3:0] FS_NOT  = 4'b1011;
    localparam logic [3:0] FS_MOVB = 4'b1100;
    localparam logic [3:0] FS_SHR  = 4'b1101;
    localparam logic [3:0] FS_SHL  = 4'b1110;

    // Flags word is {V,C,N,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/dp_function_unit.sv
// rtl/dp_function_unit.sv - combinational ALU/shifter producing F and {V,C,N,Z}
module dp_function_unit
    import simple_datapath_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       FS,
    output logic [WIDTH-1:0] F,
    output logic             V,
    output logic             C,
    output logic             N,
    output logic             Z
);

    logic [WIDTH-1:0] bop;
    logic             cin;
    logic             arith;
    logic [WIDTH:0]   sum;

    // Every arithmetic code is A + bop + cin; decrement adds all-ones
    always_comb begin
        bop   = '0;
        cin   = 1'b0;
        arith = 1'b1;
        case (FS)
            FS_INC:  cin = 1'b1;
            FS_ADD:  bop = B;
            FS_ADDC: begin bop = B;  cin = 1'b1; end
            FS_SUBB: bop = ~B;
            FS_SUB:  begin bop = ~B; cin = 1'b1; end
            FS_DEC:  bop = '1;
            default: arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, A} + {1'b0, bop} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        F = '0;
        case (FS)
            FS_TRA, 4'b0111: F = A;
            FS_AND:          F = A & B;
            FS_OR:           F = A | B;
            FS_XOR:          F = A ^ B;
            FS_NOT:          F = ~A;
            FS_MOVB:         F = B;
            FS_SHR:          F = {1'b0, B[WIDTH-1:1]};
            FS_SHL:          F = {B[WIDTH-2:0], 1'b0};
            default:         F = arith ? sum[WIDTH-1:0] : '0;
        endcase
    end

    assign C = arith & sum[WIDTH];
    assign V = arith & (A[WIDTH-1] == bop[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
    assign N = F[WIDTH-1];
    assign Z = (F == '0);

endmodule

// File: rtl/simple_datapath.sv
// rtl/simple_datapath.sv - register file, function unit, data memory and flags; DP_FLAGS_EN enables the flags register
module simple_datapath
    import simple_datapath_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MEM_DEPTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [1:0]       DA,
    input  logic [1:0]       AA,
    input  logic [1:0]       BA,
    input  logic             MB,
    input  logic [3:0]       FS,
    input  logic             MD,
    input  logic             RW,
    input  logic             MW,
    input  logic [3:0]       Constant,
    output logic [WIDTH-1:0] AData,
    output logic [WIDTH-1:0] BData,
    output logic [WIDTH-1:0] FOut,
    output logic [3:0]       Flags
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [WIDTH-1:0] regs [4];
    logic [WIDTH-1:0] mem  [MEM_DEPTH];
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_rdata;
    logic             fu_v, fu_c, fu_n, fu_z;

    assign AData     = regs[AA];
    assign BData     = MB ? WIDTH'(Constant) : regs[BA];
    assign mem_addr  = AData[AW-1:0];
    assign mem_rdata = mem[mem_addr];

    dp_function_unit #(.WIDTH(WIDTH)) u_fu (
        .A  (AData),
        .B  (BData),
        .FS (FS),
        .F  (FOut),
        .V  (fu_v),
        .C  (fu_c),
        .N  (fu_n),
        .Z  (fu_z)
    );

    // Both writes sample pre-edge values, so a load and store to one address see the old word
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            for (int j = 0; j < MEM_DEPTH; j++) mem[j] <= '0;
        end else begin
            if (RW) regs[DA] <= MD ? mem_rdata : FOut;
            if (MW) mem[mem_addr] <= BData;
        end
    end

`ifdef DP_FLAGS_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            Flags <= 4'b0000;
        end else begin
            Flags[FLAG_V] <= fu_v;
            Flags[FLAG_C] <= fu_c;
            Flags[FLAG_N] <= fu_n;
            Flags[FLAG_Z] <= fu_z;
        end
    end
`else
    logic unused_status;
    assign unused_status = ^{fu_v, fu_c, fu_n, fu_z};
    assign Flags = 4'b0000;
`endif

endmodule

// File: doc/simple_datapath.md
Name: simple_datapath

Overview:
- Execution end of the Simple Computer control interface. Consumes the per-cycle control word (DA, AA, BA, MB, FS, MD, RW, MW, Constant) from the control unit.
- Holds the register file, function unit, data memory and status flags.
- Returns bus A (AData) to the control unit for jump and branch evaluation.
- One instruction completes per CLK edge. There is no pipelining.

Parameters:
- WIDTH, 4, datapath word width in bits (registers, buses, memory words).
- MEM_DEPTH, 16, data memory word count. Must be a power of two and ≤ 2^WIDTH.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  synchronous active-low reset.
- DA  in  2  destination register index.
- AA  in  2  bus A source register index.
- BA  in  2  bus B source register index.
- MB  in  1  bus B mux select: 0 = register[BA], 1 = Constant.
- FS  in  4  function select.
- MD  in  1  write-back mux select: 0 = function result F, 1 = memory read data.
- RW  in  1  register write enable.
- MW  in  1  memory write enable.
- Constant  in  4  immediate, zero-extended to WIDTH.
- AData  out  WIDTH  bus A (register[AA]), combinational; goes to the control unit.
- BData  out  WIDTH  bus B after the MB mux, combinational.
- FOut  out  WIDTH  function unit result, combinational.
- Flags  out  4  registered status {V,C,N,Z}.

Behaviour:
- Register file: R0..R3, each WIDTH bits. Two asynchronous read ports (AA, BA) and one synchronous write port.
  - Read-during-write returns the old value; the new value is visible after the edge.
- Function unit (combinational), FS encoding:
  - 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+1; 0100 A+~B; 0101 A+~B+1 (A−B); 0110 A−1; 0111 A
  - 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A; 1100 B; 1101 B>>1 (zero fill); 1110 B<<1 (zero fill); 1111 = 0
- Arithmetic is WIDTH+1 wide internally.
  - C = carry out; A−1 is computed as A + all-ones.
  - V = signed overflow for the arithmetic codes (0001–0110), 0 otherwise.
  - N = F[MSB]; Z = (F == 0).
  - C and V are 0 for logic/shift codes.
- Data memory: MEM_DEPTH × WIDTH.
  - Address = AData[log2(MEM_DEPTH)-1:0].
  - Asynchronous read. On a rising edge with MW=1, mem[addr] <= BData.
- Write-back: on a rising edge with RW=1, R[DA] <= (MD ? mem_read : F).
  - mem_read is the pre-edge value, including when MW=1 to the same address in the same cycle.
- RW and MW both set in one cycle: both writes occur on the same edge, independently.
- Flags register: updated every edge from the current F, independent of RW.
- Reset (RST_N=0 at an edge):
  - R0..R3 <= 0, Flags <= 0, all memory words <= 0.
  - RW and MW are ignored during that edge.
  - Combinational outputs follow the reset state from the next cycle.
  - Reset asserted mid-program discards that cycle's writes. There is no partial write.
- Out-of-range or illegal codes: FS=1111 yields F=0 and Z=1 at the edge. No other illegal inputs exist.

Optional Feature:
- Macro DP_FLAGS_EN.
- Defined: flags register and update logic present as above.
- Undefined: no flags flops. Flags output is tied to 4'b0000. The rest of the behaviour is unchanged.

Decomposition:
- Shared package/header holds:
  - FS code constants (FS_TRA, FS_INC, FS_ADD, FS_ADDC, FS_SUBB, FS_SUB, FS_DEC, FS_AND, FS_OR, FS_XOR, FS_NOT, FS_MOVB, FS_SHR, FS_SHL).
  - Flag bit index constants.
- One sub-module: dp_function_unit (A, B, FS in; F, V, C, N, Z out), purely combinational.
- Register file and memory are inline arrays in simple_datapath.

Test Plan:
- Reset: drive RST_N=0 for one edge with RW=1, DA=1, FS=0001 → R0..R3=0, Flags=0000, mem[0..15]=0.
- Load immediate then add:
  - Cycle 1: MB=1, Constant=3, FS=1100, RW=1, DA=1 → R1=3.
  - Cycle 2: same with Constant=2, DA=2 → R2=2.
  - Cycle 3: AA=1, BA=2, MB=0, FS=0010, DA=3 → R3=5, Flags Z=0, N=0, C=0, V=0.
- Overflow/carry: R1=7, R2=1, FS=0010 → F=8, N=1, V=1, C=0.
  - Then R1=15, R2=1, FS=0010 → F=0, Z=1, C=1, V=0.
- Memory store/load:
  - AA=2 (R2=2), BA=3 (R3=5), MW=1 → mem[2]=5.
  - Next cycle AA=2, MD=1, RW=1, DA=0 → R0=5.
- Same-cycle conflicts:
  - RW=1 and MW=1 with MD=1 at one address holding 4, BData=9 → register gets 4, memory becomes 9.
  - Read-during-write: AData reflects the old register value in the write cycle.
- Mid-program reset: R1=6, then RST_N=0 with RW=1, DA=1, FS=0001 → R1=0, not 7. With DP_FLAGS_EN undefined, Flags stays 0000 throughout.
